// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file writeback arbiter with pending-write scoreboard
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] qaddr1,
   input  logic [ADDR_W-1:0] qaddr2,
   output logic              busy1,
   output logic              busy2,
   output logic [NREG-1:0]   busy_mask
);

   // 1 = source B won the most recent grant, so A has priority on the next conflict
   logic              last_b;
   logic              grant_a;
   logic              grant_b;
   logic              grant;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_data;
   logic [NREG-1:0]   mask_next;

   // Round-robin arbitration; nothing is accepted while reset is held
   always_comb begin
      grant_a = rst && a_valid && (!b_valid || last_b);
      grant_b = rst && b_valid && (!a_valid || !last_b);
      grant   = grant_a || grant_b;
      g_addr  = grant_b ? b_addr : a_addr;
      g_data  = grant_b ? b_data : a_data;
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   // Next scoreboard: grant clears, a younger reservation wins over the clear, flush wins over all
   always_comb begin
      mask_next = busy_mask;
      if (grant) begin
         mask_next[g_addr] = 1'b0;
      end
      if (rsv_valid) begin
         mask_next[rsv_addr] = 1'b1;
      end
      if (flush) begin
         mask_next = '0;
      end
      mask_next[0] = 1'b0;
   end

   // Register the granted write, round-robin pointer and scoreboard
   always_ff @(posedge clk) begin
      if (!rst) begin
         we        <= 1'b0;
         waddr     <= '0;
         wdata     <= '0;
         last_b    <= 1'b1;
         busy_mask <= '0;
      end else begin
         busy_mask <= mask_next;
         if (grant) begin
            we     <= (g_addr != '0);
            waddr  <= g_addr;
            wdata  <= g_data;
            last_b <= grant_b;
         end else begin
            we <= 1'b0;
         end
      end
   end

   // Register 0 is never pending, so its queries fall out of the mask as 0
   assign busy1 = busy_mask[qaddr1];
   assign busy2 = busy_mask[qaddr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] mask;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        rsv_valid;
   logic [4:0]  rsv_addr;
   logic        a_valid;
   logic        a_ready;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_addr;
   logic [31:0] b_data;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  qaddr1;
   logic [4:0]  qaddr2;
   logic        busy1;
   logic        busy2;
   logic [31:0] busy_mask;

   int checks = 0;
   int errors = 0;

   exp_t        exp_q[$];
   logic        m_lg_b;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic [31:0] m_mask;

   regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .we(we), .waddr(waddr), .wdata(wdata),
      .qaddr1(qaddr1), .qaddr2(qaddr2), .busy1(busy1), .busy2(busy2),
      .busy_mask(busy_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard consumer: compares the registered outputs against the entry pushed last cycle
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (we !== e.we || waddr !== e.addr || wdata !== e.data || busy_mask !== e.mask) begin
            errors++;
            $display("FAIL scoreboard: got we=%b waddr=%0d wdata=%h mask=%h, want we=%b waddr=%0d wdata=%h mask=%h",
                     we, waddr, wdata, busy_mask, e.we, e.addr, e.data, e.mask);
         end
      end
   end

   // Drive one cycle of stimulus and push the reference result for the following cycle
   task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic rv, input logic [4:0] ra, input logic fl);
      exp_t e;
      logic ga;
      logic gb;
      logic [4:0] ga_addr;
      @(posedge clk);
      #1;
      rst = r; a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      rsv_valid = rv; rsv_addr = ra; flush = fl;
      #1;
      e.we = 1'b0;
      if (!r) begin
         m_lg_b = 1'b1; m_waddr = '0; m_wdata = '0; m_mask = '0;
      end else begin
         ga = av && (!bv || m_lg_b);
         gb = bv && (!av || !m_lg_b);
         if (ga || gb) begin
            ga_addr = gb ? ba : aa;
            m_waddr = ga_addr;
            m_wdata = gb ? bd : ad;
            e.we = (ga_addr != 5'd0);
            m_lg_b = gb;
            m_mask[ga_addr] = 1'b0;
         end
         if (rv) m_mask[ra] = 1'b1;
         if (fl) m_mask = '0;
         m_mask[0] = 1'b0;
      end
      e.addr = m_waddr; e.data = m_wdata; e.mask = m_mask;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b0);
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got a=%b b=%b, want 0 0", a_ready, b_ready);
      end
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (we !== 1'b0 || busy_mask !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: got we=%b mask=%h, want 0 0", we, busy_mask);
      end
   endtask

   task automatic test_a_only();
      step(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         errors++;
         $display("FAIL a_only_ready: got a=%b b=%b, want 1 0", a_ready, b_ready);
      end
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h1234) begin
         errors++;
         $display("FAIL a_only_write: got we=%b waddr=%0d wdata=%h, want 1 5 1234", we, waddr, wdata);
      end
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (we !== 1'b0 || waddr !== 5'd5) begin
         errors++;
         $display("FAIL a_only_hold: got we=%b waddr=%0d, want 0 5", we, waddr);
      end
   endtask

   task automatic test_round_robin();
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 5'd3, 32'hA000 + i, 1'b1, 5'd4, 32'hB000 + i, 1'b0, 5'd0, 1'b0);
         checks++;
         if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
            errors++;
            $display("FAIL rr_grant%0d: got a=%b b=%b, want a=%b", i, a_ready, b_ready, (i % 2 == 0));
         end
         if (i > 0) begin
            checks++;
            if (we !== 1'b1 || waddr !== ((i % 2 == 1) ? 5'd3 : 5'd4)) begin
               errors++;
               $display("FAIL rr_write%0d: got we=%b waddr=%0d", i, we, waddr);
            end
         end
      end
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (we !== 1'b1 || waddr !== 5'd4 || wdata !== 32'hB003) begin
         errors++;
         $display("FAIL rr_last: got we=%b waddr=%0d wdata=%h, want 1 4 b003", we, waddr, wdata);
      end
   endtask

   task automatic test_scoreboard();
      qaddr1 = 5'd7; qaddr2 = 5'd3;
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (busy1 !== 1'b1 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL sb_reserve: got busy1=%b busy2=%b, want 1 0", busy1, busy2);
      end
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hCAFE, 1'b0, 5'd0, 1'b0);
      checks++;
      if (b_ready !== 1'b1 || busy1 !== 1'b1) begin
         errors++;
         $display("FAIL sb_grant: got b_ready=%b busy1=%b, want 1 1", b_ready, busy1);
      end
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (busy1 !== 1'b0 || we !== 1'b1 || waddr !== 5'd7) begin
         errors++;
         $display("FAIL sb_release: got busy1=%b we=%b waddr=%0d, want 0 1 7", busy1, we, waddr);
      end
   endtask

   task automatic test_same_cycle();
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
      step(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0);
      checks++;
      if (busy_mask[9] !== 1'b1) begin
         errors++;
         $display("FAIL set_wins: got bit9=%b, want 1", busy_mask[9]);
      end
      step(1'b1, 1'b1, 5'd9, 32'h98, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1);
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (busy_mask !== 32'h0 || we !== 1'b1 || wdata !== 32'h98) begin
         errors++;
         $display("FAIL flush_wins: got mask=%h we=%b wdata=%h, want 0 1 98", busy_mask, we, wdata);
      end
   endtask

   task automatic test_addr0();
      qaddr1 = 5'd0;
      step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("FAIL x0_ready: got a_ready=%b, want 1", a_ready);
      end
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (we !== 1'b0 || wdata !== 32'hFFFFFFFF || busy_mask[0] !== 1'b0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL x0_write: got we=%b wdata=%h bit0=%b busy1=%b, want 0 ffffffff 0 0",
                  we, wdata, busy_mask[0], busy1);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b0);
      step(1'b0, 1'b1, 5'd21, 32'h21, 1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 1'b0);
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0 || busy_mask[20] !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_ready: got a=%b b=%b bit20=%b, want 0 0 1", a_ready, b_ready, busy_mask[20]);
      end
      step(1'b1, 1'b1, 5'd21, 32'h21, 1'b1, 5'd22, 32'h22, 1'b0, 5'd0, 1'b0);
      checks++;
      if (we !== 1'b0 || busy_mask !== 32'h0 || a_ready !== 1'b1 || b_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_state: got we=%b mask=%h a=%b b=%b, want 0 0 1 0",
                  we, busy_mask, a_ready, b_ready);
      end
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; rsv_valid = 1'b0; rsv_addr = '0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      qaddr1 = '0; qaddr2 = '0;
      m_lg_b = 1'b1; m_waddr = '0; m_wdata = '0; m_mask = '0;
      test_reset();
      test_a_only();
      test_round_robin();
      test_scoreboard();
      test_same_cycle();
      test_addr0();
      test_reset_mid();
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the register file's single write port between two writeback sources: A (ALU/execute result) and B (load data from memory stage).
- Registers the winning write onto we/waddr/wdata, one write per cycle.
- Keeps a per-register pending-write scoreboard. Decode reserves a destination register; the bit clears when the matching write is granted. Decode queries the scoreboard for RAW stall decisions.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
NREG, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
flush  in  1  clear all scoreboard bits (pipeline flush)
rsv_valid  in  1  decode reserves destination register
rsv_addr  in  ADDR_W  register being reserved
a_valid  in  1  source A write request
a_ready  out  1  source A request accepted this cycle
a_addr  in  ADDR_W  source A destination
a_data  in  DATA_W  source A data
b_valid  in  1  source B write request
b_ready  out  1  source B request accepted this cycle
b_addr  in  ADDR_W  source B destination
b_data  in  DATA_W  source B data
we  out  1  register file write enable
waddr  out  ADDR_W  register file write address
wdata  out  DATA_W  register file write data
qaddr1  in  ADDR_W  scoreboard query address 1
qaddr2  in  ADDR_W  scoreboard query address 2
busy1  out  1  write pending for qaddr1
busy2  out  1  write pending for qaddr2
busy_mask  out  NREG  full scoreboard, bit i = register i pending

Behaviour:
- Reset (rst==0 at posedge): we=0, waddr=0, wdata=0, busy_mask=0, last_grant=B, so A wins the first conflict. a_ready/b_ready=0 while rst==0.
- Handshake: a request transfers in the cycle where valid&&ready. Sources hold valid/addr/data stable until accepted. ready is combinational from valid and last_grant. At most one of a_ready/b_ready is high per cycle.
- Arbitration:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the source not in last_grant (round-robin).
  - last_grant updates only on an actual grant.
- Write output, latency 1: at the posedge ending the grant cycle, waddr/wdata load the granted addr/data. we=1 for exactly that next cycle, unless the granted addr==0.
- Address 0: the request is accepted (ready=1) but produces we=0. waddr/wdata still update.
- No grant in a cycle: we=0 next cycle; waddr/wdata hold their previous values.
- Scoreboard, updated at posedge when rst==1:
  - Set bit rsv_addr if rsv_valid && rsv_addr!=0.
  - Clear bit granted_addr on a grant.
  - Same register reserved and cleared in the same cycle: set wins, because the reservation is for a younger instruction.
  - flush clears every bit and overrides any reservation in the same cycle. Grants and writes proceed normally during flush.
  - Bit 0 is always 0.
- Queries: busy1=busy_mask[qaddr1] and busy2=busy_mask[qaddr2], purely combinational from the registered mask. A query of address 0 returns 0.
- Clearing the bit in the grant cycle lets the consumer issue in the following cycle, which is the cycle the register file write occurs. The register file's same-cycle write bypass supplies the data.
- Reset mid-operation: pending requests are dropped with no ready and no write. The scoreboard clears. Sources must re-present their requests after reset.
- Releasing or re-reserving an unreserved register is legal. Clearing a register that is already 0 is a no-op.

Test Plan:
- Reset then idle → we=0, busy_mask=0, a_ready=b_ready=0 during reset.
- A only: a_valid, a_addr=5, a_data=0x1234 → a_ready=1 same cycle; next cycle we=1, waddr=5, wdata=0x1234; then we=0.
- Both valid for 4 cycles, A(addr 3) and B(addr 4), each re-presented after acceptance → grant order A,B,A,B; we pulses 4 consecutive cycles with waddr 3,4,3,4.
- Reserve x7, query qaddr1=7 → busy1=1 next cycle. B writes x7 → busy1=0 the cycle after the grant, coincident with we=1, waddr=7.
- Same cycle rsv_valid on x9 and grant on x9 (bit already set) → bit 9 stays 1. With flush asserted in the same cycle instead → busy_mask=0.
- Request to x0 with data 0xFFFFFFFF → a_ready=1, next cycle we=0. rsv on x0 → busy_mask[0]=0. Reset asserted while both valid → no ready, no write, mask cleared.
